// File: rtl/ahb_ram_ext_if.sv
// AHB-Lite bus bundle between a master (or matrix) and the ahb_ram_ext slave.
interface ahb_ram_ext_if;
  logic        HSEL;
  logic        HWRITE;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport slave (
    input  HSEL, HWRITE, HREADY, HTRANS, HSIZE, HADDR, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HWRITE, HREADY, HTRANS, HSIZE, HADDR, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_ram_ext.sv
// AHB-Lite slave RAM with byte/half/word writes, configurable wait states and a
// two-cycle ERROR response for misaligned, out-of-range or unsupported transfers.
module ahb_ram_ext #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic          HCLK,
  input logic          HRESET,
  ahb_ram_ext_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e                r_state, w_state_d;
  logic [2:0]            r_cnt, w_cnt_d;
  logic                  r_write;
  logic [3:0]            r_strb;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [2**ADDR_WIDTH];

  logic                  w_req;
  logic                  w_acc;
  logic                  w_err;
  logic [3:0]            w_strb;
  logic [ADDR_WIDTH-1:0] w_addr_idx;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic [31:0]           w_rd_word;
  logic                  w_rd_load;
  logic                  w_commit;
  logic                  w_unused_htrans;

  assign w_unused_htrans = bus.HTRANS[0];

  assign w_req      = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign w_acc      = w_req & ((r_state == StIdle) | (r_state == StData) | (r_state == StErr2));
  assign w_addr_idx = bus.HADDR[ADDR_WIDTH+1:2];
  assign w_commit   = (r_state == StData) & r_write;

  assign w_err = (bus.HSIZE > 3'd2)
               | ((bus.HSIZE == 3'd1) & bus.HADDR[0])
               | ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00))
               | ((bus.HADDR >> (ADDR_WIDTH + 2)) != 32'd0);

  always_comb begin
    case (bus.HSIZE)
      3'd0:    w_strb = 4'b0001 << bus.HADDR[1:0];
      3'd1:    w_strb = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_strb = 4'b1111;
    endcase
  end

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= StIdle;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle, StData, StErr2: begin
        w_state_d = StIdle;
        if (w_req) begin
          if (w_err) begin
            w_state_d = StErr1;
          end else if (WAIT_STATES != 0) begin
            w_state_d = StWait;
            w_cnt_d   = 3'(WAIT_STATES);
          end else begin
            w_state_d = StData;
          end
        end
      end
      StWait: begin
        if (r_cnt <= 3'd1) w_state_d = StData;
        else               w_cnt_d   = r_cnt - 3'd1;
      end
      StErr1:  w_state_d = StErr2;
      default: w_state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 1'b0;
    case (r_state)
      StWait: bus.HREADYOUT = 1'b0;
      StErr1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 1'b1;
      end
      StErr2:  bus.HRESP = 1'b1;
      default: ;
    endcase
  end

  assign bus.HRDATA = r_rdata;

  // Read word, with byte-wise forwarding of a write committing at this same edge
  always_comb begin
    w_rd_idx  = (r_state == StWait) ? r_widx : w_addr_idx;
    w_rd_word = r_mem[w_rd_idx];
    for (int i = 0; i < 4; i++) begin
      if (w_commit && r_strb[i] && (r_widx == w_rd_idx)) begin
        w_rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign w_rd_load = (w_state_d == StData) & ((r_state == StWait) ? ~r_write : ~bus.HWRITE);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_write <= 1'b0;
      r_strb  <= 4'b0000;
      r_widx  <= '0;
      r_rdata <= 32'd0;
    end else begin
      if (w_acc) begin
        r_write <= bus.HWRITE;
        r_strb  <= w_strb;
        r_widx  <= w_addr_idx;
      end
      if (w_rd_load) r_rdata <= w_rd_word;
    end
  end

  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_strb[i]) r_mem[r_widx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_ram_ext.sv
// Directed bench for ahb_ram_ext: three instances (0, 2 and 3 wait states) on a shared
// driver, one selected at a time, with HREADY fed back from the selected slave.
module tb_ahb_ram_ext;

  logic        clk;
  logic        rst;
  logic [1:0]  dsel;
  logic        hsel;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        w_ready;
  logic        w_resp;
  logic [31:0] w_rdata;

  int errs;
  int checks;

  int          waits;
  logic [31:0] rd;
  logic        rsp0;
  logic        rsp;

  ahb_ram_ext_if b0 ();
  ahb_ram_ext_if b2 ();
  ahb_ram_ext_if b3 ();

  ahb_ram_ext #(.ADDR_WIDTH(6), .WAIT_STATES(0)) u_ws0 (.HCLK(clk), .HRESET(rst), .bus(b0));
  ahb_ram_ext #(.ADDR_WIDTH(6), .WAIT_STATES(2)) u_ws2 (.HCLK(clk), .HRESET(rst), .bus(b2));
  ahb_ram_ext #(.ADDR_WIDTH(6), .WAIT_STATES(3)) u_ws3 (.HCLK(clk), .HRESET(rst), .bus(b3));

  assign b0.HSEL = hsel && (dsel == 2'd0);
  assign b2.HSEL = hsel && (dsel == 2'd1);
  assign b3.HSEL = hsel && (dsel == 2'd2);
  assign b0.HWRITE = hwrite; assign b2.HWRITE = hwrite; assign b3.HWRITE = hwrite;
  assign b0.HTRANS = htrans; assign b2.HTRANS = htrans; assign b3.HTRANS = htrans;
  assign b0.HSIZE  = hsize;  assign b2.HSIZE  = hsize;  assign b3.HSIZE  = hsize;
  assign b0.HADDR  = haddr;  assign b2.HADDR  = haddr;  assign b3.HADDR  = haddr;
  assign b0.HWDATA = hwdata; assign b2.HWDATA = hwdata; assign b3.HWDATA = hwdata;
  assign b0.HREADY = w_ready; assign b2.HREADY = w_ready; assign b3.HREADY = w_ready;

  assign w_ready = (dsel == 2'd0) ? b0.HREADYOUT : (dsel == 2'd1) ? b2.HREADYOUT : b3.HREADYOUT;
  assign w_resp  = (dsel == 2'd0) ? b0.HRESP     : (dsel == 2'd1) ? b2.HRESP     : b3.HRESP;
  assign w_rdata = (dsel == 2'd0) ? b0.HRDATA    : (dsel == 2'd1) ? b2.HRDATA    : b3.HRDATA;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  // Single transfer from an idle slave; reports data-phase stall count and responses.
  task automatic xfer(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output int nwait, output logic [31:0] rdat,
                      output logic r0, output logic r1);
    addr_phase(wr, sz, a);
    @(posedge clk); #1;
    idle_bus();
    hwdata = wd;
    nwait  = 0;
    @(negedge clk);
    r0 = w_resp;
    while (!w_ready && nwait < 20) begin
      nwait++;
      @(negedge clk);
    end
    rdat = w_rdata;
    r1   = w_resp;
    @(posedge clk); #1;
  endtask

  initial begin
    errs = 0; checks = 0;
    rst = 1'b0; dsel = 2'd0;
    hsel = 1'b0; hwrite = 1'b0; htrans = 2'b00; hsize = 3'd0; haddr = 32'd0; hwdata = 32'd0;

    // Reset, asserted and released away from clock edges
    #2 rst = 1'b1;
    #1;
    chk("rst_ready_ws0", 32'(b0.HREADYOUT), 32'd1);
    chk("rst_resp_ws0", 32'(b0.HRESP), 32'd0);
    chk("rst_rdata_ws0", b0.HRDATA, 32'h0);
    chk("rst_ready_ws2", 32'(b2.HREADYOUT), 32'd1);
    chk("rst_rdata_ws3", b3.HRDATA, 32'h0);
    @(posedge clk);
    #8 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(w_ready), 32'd1);

    // Zero-wait write then back-to-back read of the same word (forwarded)
    dsel = 2'd0;
    addr_phase(1'b1, 3'd2, 32'h10);
    @(posedge clk); #1;
    addr_phase(1'b0, 3'd2, 32'h10);
    hwdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_ready_wdata", 32'(w_ready), 32'd1);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("t2_ready_rdata", 32'(w_ready), 32'd1);
    chk("t2_rdata_fwd", w_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Word, byte, half writes pipelined, then forwarded read
    addr_phase(1'b1, 3'd2, 32'h20);
    @(posedge clk); #1;
    addr_phase(1'b1, 3'd0, 32'h21);
    hwdata = 32'h00000000;
    @(posedge clk); #1;
    addr_phase(1'b1, 3'd1, 32'h22);
    hwdata = 32'hFFFF11FF;
    @(posedge clk); #1;
    addr_phase(1'b0, 3'd2, 32'h20);
    hwdata = 32'hAABBFFFF;
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("t3_rdata_fwd", w_rdata, 32'hAABB1100);
    @(posedge clk); #1;
    xfer(1'b0, 3'd2, 32'h20, 32'h0, waits, rd, rsp0, rsp);
    chk("t3_rdata_mem", rd, 32'hAABB1100);
    chk("t3_waits", 32'(waits), 32'd0);

    // Two wait states
    dsel = 2'd1;
    xfer(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, waits, rd, rsp0, rsp);
    chk("t4_write_waits", 32'(waits), 32'd2);
    chk("t4_write_resp", 32'(rsp), 32'd0);
    xfer(1'b0, 3'd2, 32'h10, 32'h0, waits, rd, rsp0, rsp);
    chk("t4_read_waits", 32'(waits), 32'd2);
    chk("t4_read_data", rd, 32'hDEADBEEF);
    chk("t4_read_resp", 32'(rsp0), 32'd0);

    // Error responses
    dsel = 2'd0;
    xfer(1'b1, 3'd2, 32'h00, 32'h01234567, waits, rd, rsp0, rsp);
    chk("t5_setup_waits", 32'(waits), 32'd0);
    xfer(1'b1, 3'd2, 32'h02, 32'hBAD0BAD0, waits, rd, rsp0, rsp);
    chk("t5_mis_err1_len", 32'(waits), 32'd1);
    chk("t5_mis_err1_resp", 32'(rsp0), 32'd1);
    chk("t5_mis_err2_resp", 32'(rsp), 32'd1);
    xfer(1'b0, 3'd2, 32'h100, 32'h0, waits, rd, rsp0, rsp);
    chk("t5_oor_err1_len", 32'(waits), 32'd1);
    chk("t5_oor_err1_resp", 32'(rsp0), 32'd1);
    chk("t5_oor_err2_resp", 32'(rsp), 32'd1);
    xfer(1'b1, 3'd1, 32'h01, 32'hFFFFFFFF, waits, rd, rsp0, rsp);
    chk("t5_half_mis_resp", 32'(rsp0), 32'd1);
    xfer(1'b1, 3'd3, 32'h00, 32'hFFFFFFFF, waits, rd, rsp0, rsp);
    chk("t5_size3_resp", 32'(rsp0), 32'd1);
    xfer(1'b0, 3'd2, 32'h00, 32'h0, waits, rd, rsp0, rsp);
    chk("t5_mem_unchanged", rd, 32'h01234567);
    chk("t5_ok_resp", 32'(rsp), 32'd0);

    // Read accepted during ERR2 completes OKAY
    addr_phase(1'b0, 3'd2, 32'h100);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("t5_err1_ready", 32'(w_ready), 32'd0);
    chk("t5_err1_hresp", 32'(w_resp), 32'd1);
    @(posedge clk); #1;
    addr_phase(1'b0, 3'd2, 32'h00);
    @(negedge clk);
    chk("t5_err2_ready", 32'(w_ready), 32'd1);
    chk("t5_err2_hresp", 32'(w_resp), 32'd1);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("t5_after_err_ready", 32'(w_ready), 32'd1);
    chk("t5_after_err_resp", 32'(w_resp), 32'd0);
    chk("t5_after_err_data", w_rdata, 32'h01234567);
    @(posedge clk); #1;

    // Reset during the second wait cycle of a write
    dsel = 2'd2;
    xfer(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, waits, rd, rsp0, rsp);
    chk("t6_setup_waits", 32'(waits), 32'd3);
    xfer(1'b0, 3'd2, 32'h30, 32'h0, waits, rd, rsp0, rsp);
    chk("t6_setup_read", rd, 32'hCAFEF00D);
    addr_phase(1'b1, 3'd2, 32'h30);
    @(posedge clk); #1;
    idle_bus();
    hwdata = 32'h12345678;
    @(posedge clk);
    #2 chk("t6_in_wait", 32'(w_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(w_ready), 32'd1);
    chk("t6_rst_resp", 32'(w_resp), 32'd0);
    chk("t6_rst_rdata", w_rdata, 32'h0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 3'd2, 32'h30, 32'h0, waits, rd, rsp0, rsp);
    chk("t6_no_commit", rd, 32'hCAFEF00D);
    chk("t6_read_waits", 32'(waits), 32'd3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
